// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for a given chunk count; never narrower than one bit.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  // The carry into the top bit is only meaningful on the last chunk, where it feeds overflow.
  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: processes CHUNK bits per cycle with a registered carry between chunks.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             co_chunk, c_msb;
  logic             accept, last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          next_state = IDLE;
          last       = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Select the active chunk; B is inverted here so subtraction reuses the adder.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK] ^ {CHUNK{sub_q}};
      end
    end
  end

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .a        (a_chunk),
    .b        (b_chunk),
    .ci       (carry_q),
    .s        (sum_chunk),
    .co       (co_chunk),
    .c_msb_in (c_msb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        sub_q   <= Sub;
        carry_q <= Sub ? 1'b1 : Cin;
        cnt     <= '0;
      end else if (state == RUN) begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt == CW'(k)) S[k*CHUNK +: CHUNK] <= sum_chunk;
        end
        carry_q <= co_chunk;
        cnt     <= cnt + CW'(1);
        if (last) begin
          Cout <= co_chunk;
          Ovf  <= co_chunk ^ c_msb;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder at WIDTH=8, CHUNK=2.
module tb_chunked_serial_adder;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             Cin, Sub;
  logic             busy, done;
  logic [WIDTH-1:0] S;
  logic             Cout, Ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  chunked_serial_adder #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Sub   (Sub),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic on plain integers.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                       output logic [7:0] s, output logic cout, output logic ovf);
    int ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r    = ua - ub;
      sr   = sa - sb;
      cout = (ua >= ub);
    end else begin
      r    = ua + ub + int'(cin);
      sr   = sa + sb + int'(cin);
      cout = (r > 255);
    end
    s   = r[7:0];
    ovf = (sr > 127) || (sr < -128);
  endtask

  // Called at a negedge; pulses start, then waits (bounded) for done.
  task automatic applyStimulus(input logic [7:0] a_i, input logic [7:0] b_i, input logic cin_i,
                               input logic sub_i, input bit scramble,
                               output int busy_cycles, output bit got_done);
    A = a_i; B = b_i; Cin = cin_i; Sub = sub_i; start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (scramble) begin
        A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic runVector(input string tag, input logic [7:0] a_i, input logic [7:0] b_i,
                           input logic cin_i, input logic sub_i, input bit scramble,
                           input logic [7:0] es, input logic ec, input logic eo);
    int  bc;
    bit  gd;
    applyStimulus(a_i, b_i, cin_i, sub_i, scramble, bc, gd);
    checkOutput({tag, " done"}, 32'(gd), 32'd1);
    checkOutput({tag, " busy_cycles"}, 32'(bc), 32'(NCHUNK));
    checkOutput({tag, " S"}, 32'(S), 32'(es));
    checkOutput({tag, " Cout"}, 32'(Cout), 32'(ec));
    checkOutput({tag, " Ovf"}, 32'(Ovf), 32'(eo));
    checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, " done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, " S_hold"}, 32'(S), 32'(es));
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] ms;
    logic       mc, mo;
    int         n;
    logic [7:0] ra, rb;
    logic       rc, rs;

    vecs.push_back('{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0});
    vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h55, 8'h55, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset S", 32'(S), 32'd0);
    checkOutput("reset Cout", 32'(Cout), 32'd0);
    checkOutput("reset Ovf", 32'(Ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0,
                vecs[i].s, vecs[i].cout, vecs[i].ovf);

    // Start pulsed mid-operation must be ignored.
    A = 8'h3C; B = 8'h05; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'hAA; B = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    checkOutput("ignore done_delay", 32'(n), 32'd2);
    checkOutput("ignore S", 32'(S), 32'h41);
    @(negedge clk);
    checkOutput("ignore no_restart", 32'(busy), 32'd0);

    // Start held high through done launches the next operation on the done cycle.
    A = 8'h11; B = 8'h22; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 8'h01; B = 8'h02;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    checkOutput("b2b first done", 32'(done), 32'd1);
    checkOutput("b2b first S", 32'(S), 32'h33);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b second busy", 32'(busy), 32'd1);
    checkOutput("b2b done_cleared", 32'(done), 32'd0);
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    checkOutput("b2b second delay", 32'(n), 32'(NCHUNK));
    checkOutput("b2b second S", 32'(S), 32'h03);
    @(negedge clk);

    // Reset during RUN discards the operation.
    A = 8'h3C; B = 8'h05; Cin = 1'b0; Sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst S", 32'(S), 32'd0);
    checkOutput("midrst Cout", 32'(Cout), 32'd0);
    checkOutput("midrst Ovf", 32'(Ovf), 32'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    checkOutput("midrst no_activity", 32'(n), 32'd0);
    runVector("post_rst", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // Random operands, inputs scrambled while busy.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, ms, mc, mo);
      runVector($sformatf("rnd%0d", i), ra, rb, rc, rs, 1'b1, ms, mc, mo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
